// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
// Shares the SPI bridge's single 32-bit word bus between NUM_REQ requesters.
// Round-robin grant, one transaction outstanding, one-cycle read/write strobe,
// response routed back to the granted requester, response pulses drained
// before the next grant.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN (WAIT abort after TIMEOUT_CYCLES,
// reported through req_err). Without it, WAIT lasts until the response arrives
// and req_err is tied low.
//
// Ports:
//   clk                 system clock
//   reset               synchronous active-high reset
//   req_read/req_write  per-requester level requests, held until ack
//   req_write_data      write word per requester, [32*i+31:32*i]
//   req_read_data       captured read word, valid in ack cycle and held
//   req_ack             one-cycle completion pulse per requester
//   req_err             one-cycle timeout flag, coincident with req_ack
//   spi_read/spi_write  one-cycle strobes to the bridge
//   spi_write_data      write word to the bridge, stable ISSUE..IDLE
//   spi_read_data       read word from the bridge
//   spi_read_response   bridge read done (1+ cycles)
//   spi_write_response  bridge write done (1+ cycles)
//   busy                high in every state except IDLE
//   grant_id            current or last granted requester
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_read,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [32*NUM_REQ-1:0]   req_write_data,
    output logic [31:0]             req_read_data,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      req_err,
    output logic                    spi_read,
    output logic                    spi_write,
    output logic [31:0]             spi_write_data,
    input  logic [31:0]             spi_read_data,
    input  logic                    spi_read_response,
    input  logic                    spi_write_response,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     last_grant, last_grant_next;
    logic [ID_W-1:0]     grant_id_next;
    logic                op_write, op_write_next;
    logic [DATA_W-1:0]   wdata_next;
    logic [DATA_W-1:0]   rdata_next;
    logic                spi_read_next, spi_write_next;
    logic                busy_next;
    logic [NUM_REQ-1:0]  ack_next;

    logic                found;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     cand;
    logic                match;
    logic [MAX_REQ-1:0]  active_pad;
    logic [MAX_REQ-1:0]  write_pad;
    logic [DATA_W-1:0]   wdata_arr [MAX_REQ];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0]         wait_cnt, wait_cnt_next;
    logic [NUM_REQ-1:0]  err_next;
`endif

    // Reject unsupported configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("spi_bus_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    // Per-requester write words, padded to the full id range so a 3-bit
    // index always selects a defined entry
    for (genvar g = 0; g < int'(MAX_REQ); g++) begin : g_wdata
        if (g < int'(NUM_REQ)) begin : g_used
            assign wdata_arr[g] = req_write_data[32*g +: 32];
        end else begin : g_pad
            assign wdata_arr[g] = '0;
        end
    end

    assign active_pad = MAX_REQ'(req_read | req_write);
    assign write_pad  = MAX_REQ'(req_write);

    // Only the response matching the latched op completes the transaction
    assign match = op_write ? spi_write_response : spi_read_response;

    // Round-robin pick: first active index after last_grant, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = ID_W'((int'(last_grant) + k) % int'(NUM_REQ));
            if (!found && active_pad[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        grant_id_next   = grant_id;
        op_write_next   = op_write;
        wdata_next      = spi_write_data;
        rdata_next      = req_read_data;
        spi_read_next   = 1'b0;
        spi_write_next  = 1'b0;
        ack_next        = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        err_next        = '0;
        wait_cnt_next   = wait_cnt;
`endif

        case (state)
            IDLE: begin
                if (found) begin
                    // Write wins when both bits are set; the read stays pending
                    state_next      = ISSUE;
                    last_grant_next = pick;
                    grant_id_next   = pick;
                    op_write_next   = write_pad[pick];
                    wdata_next      = wdata_arr[pick];
                    spi_write_next  = write_pad[pick];
                    spi_read_next   = !write_pad[pick];
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            WAIT: begin
                if (match) begin
                    if (!op_write) begin
                        rdata_next = spi_read_data;
                    end
                    ack_next   = NUM_REQ'(1) << grant_id;
                    state_next = DRAIN;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wait_cnt + 32'd1 == TIMEOUT_LIMIT) begin
                    ack_next   = NUM_REQ'(1) << grant_id;
                    err_next   = NUM_REQ'(1) << grant_id;
                    rdata_next = '0;
                    state_next = DRAIN;
                end else begin
                    wait_cnt_next = wait_cnt + 32'd1;
                end
`endif
            end
            DRAIN: begin
                // Hold until both responses are low so a long pulse acks once
                if (!(spi_read_response || spi_write_response)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            grant_id       <= '0;
            op_write       <= 1'b0;
            spi_write_data <= '0;
            req_read_data  <= '0;
            spi_read       <= 1'b0;
            spi_write      <= 1'b0;
            req_ack        <= '0;
            busy           <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            req_err        <= '0;
`endif
        end else begin
            state          <= state_next;
            last_grant     <= last_grant_next;
            grant_id       <= grant_id_next;
            op_write       <= op_write_next;
            spi_write_data <= wdata_next;
            req_read_data  <= rdata_next;
            spi_read       <= spi_read_next;
            spi_write      <= spi_write_next;
            req_ack        <= ack_next;
            busy           <= busy_next;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt       <= wait_cnt_next;
            req_err        <= err_next;
`endif
        end
    end

`ifndef SPI_ARB_TIMEOUT_EN
    assign req_err = '0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
// Directed-plus-random bench for spi_bus_arbiter. A reference model picks the
// expected requester by round-robin distance from the last grant; the bench
// plays the bridge and the requesters and checks strobes, acks and data.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [32*NUM_REQ-1:0] req_write_data;
    logic [31:0]           req_read_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    req_err;
    logic                  spi_read;
    logic                  spi_write;
    logic [31:0]           spi_write_data;
    logic [31:0]           spi_read_data;
    logic                  spi_read_response;
    logic                  spi_write_response;
    logic                  busy;
    logic [2:0]            grant_id;

    logic [31:0] wd [NUM_REQ];
    int n_checks = 0;
    int n_fail   = 0;
    int model_last;
    int grant_log [$];

    spi_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_read           (req_read),
        .req_write          (req_write),
        .req_write_data     (req_write_data),
        .req_read_data      (req_read_data),
        .req_ack            (req_ack),
        .req_err            (req_err),
        .spi_read           (spi_read),
        .spi_write          (spi_write),
        .spi_write_data     (spi_write_data),
        .spi_read_data      (spi_read_data),
        .spi_read_response  (spi_read_response),
        .spi_write_response (spi_write_response),
        .busy               (busy),
        .grant_id           (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_write_data[32*i +: 32] = wd[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected winner: active requester with the smallest forward distance
    // from the previous grant
    function automatic int model_pick(input logic [NUM_REQ-1:0] m, input int last);
        int best;
        int best_dist;
        int d;
        best      = -1;
        best_dist = NUM_REQ + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m[i]) begin
                d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
                if (d < best_dist) begin
                    best_dist = d;
                    best      = i;
                end
            end
        end
        return best;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_read"},  32'(spi_read), 32'd0);
        check({tag, "_spi_write"}, 32'(spi_write), 32'd0);
        check({tag, "_req_ack"},   32'(req_ack), 32'd0);
        check({tag, "_req_err"},   32'(req_err), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_wdata"},     spi_write_data, 32'd0);
        check({tag, "_rdata"},     req_read_data, 32'd0);
        check({tag, "_grant_id"},  32'(grant_id), 32'd0);
    endtask

    // Play the bridge for one transaction and act as the served requester
    task automatic serve(input logic [31:0] rd, input int delay, input int len,
                         input bit wrong, output int served);
        int          id;
        int          t;
        bit          wr;
        logic [31:0] exp_wd;
        id = model_pick(req_read | req_write, model_last);
        served = id;
        if (id < 0) begin
            check("serve_has_request", 32'd0, 32'd1);
            return;
        end
        wr         = req_write[id];
        exp_wd     = wd[id];
        model_last = id;

        t = 0;
        while (!(spi_read || spi_write) && t < 20) begin
            step();
            t++;
        end
        check("strobe_seen",  32'(spi_read | spi_write), 32'd1);
        check("strobe_write", 32'(spi_write), 32'(wr));
        check("strobe_read",  32'(spi_read), 32'(!wr));
        check("grant_id",     32'(grant_id), 32'(id));
        grant_log.push_back(int'(grant_id));
        if (wr) check("spi_wdata", spi_write_data, exp_wd);

        step();
        check("strobe_one_cycle", 32'(spi_read | spi_write), 32'd0);

        for (int d = 0; d < delay; d++) begin
            if (wrong && d == 0) begin
                if (wr) spi_read_response = 1'b1;
                else    spi_write_response = 1'b1;
            end
            step();
            spi_read_response  = 1'b0;
            spi_write_response = 1'b0;
            check("ack_before_response", 32'(req_ack), 32'd0);
        end

        spi_read_data = rd;
        if (wr) spi_write_response = 1'b1;
        else    spi_read_response  = 1'b1;

        for (int c = 1; c <= len + 1; c++) begin
            step();
            if (c == 1) begin
                check("ack_pulse", 32'(req_ack), 32'd1 << id);
                check("err_none",  32'(req_err), 32'd0);
                if (!wr) check("read_data", req_read_data, rd);
                if (wr) req_write[id] = 1'b0;
                else    req_read[id]  = 1'b0;
            end else begin
                check("ack_single", 32'(req_ack), 32'd0);
            end
            if (c == len) begin
                check("busy_in_drain", 32'(busy), 32'd1);
                if (wr) check("wdata_stable", spi_write_data, exp_wd);
                spi_read_response  = 1'b0;
                spi_write_response = 1'b0;
                spi_read_data      = $urandom;
            end
            if (c == len + 1) begin
                check("busy_back_idle", 32'(busy), 32'd0);
                if (!wr) check("read_data_held", req_read_data, rd);
            end
        end
    endtask

    initial begin
        int served;
        int id;
        reset              = 1'b1;
        req_read           = '0;
        req_write          = '0;
        spi_read_data      = '0;
        spi_read_response  = 1'b0;
        spi_write_response = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) wd[i] = '0;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        reset      = 1'b0;
        model_last = NUM_REQ - 1;
        step();

        // Write by requester 0, two-cycle response
        wd[0]        = 32'hDEADBEEF;
        req_write[0] = 1'b1;
        step();
        check("write_latency", 32'(spi_write), 32'd1);
        serve(32'h0, 0, 2, 1'b0, served);

        // Read by requester 1, two-cycle response
        req_read[1] = 1'b1;
        step();
        check("read_latency", 32'(spi_read), 32'd1);
        serve(32'h12345678, 0, 2, 1'b0, served);

        // Round-robin with both requesters holding writes
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            wd[i]        = $urandom;
            req_write[i] = 1'b1;
        end
        for (int n = 0; n < 4; n++) begin
            serve($urandom, $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, served);
            if (n < 3 && served >= 0) begin
                wd[served]        = $urandom;
                req_write[served] = 1'b1;
            end
        end
        req_write = '0;
        check("rr_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("rr_order0", 32'(grant_log[0]), 32'd0);
            check("rr_order1", 32'(grant_log[1]), 32'd1);
            check("rr_order2", 32'(grant_log[2]), 32'd0);
            check("rr_order3", 32'(grant_log[3]), 32'd1);
        end
        step();
        check("rr_idle_after", 32'(busy), 32'd0);

        // Wrong response during a read is ignored
        req_read[0] = 1'b1;
        serve($urandom, 2, 1, 1'b1, served);

        // Read and write both set: write first, read on a later grant
        wd[0]        = $urandom;
        req_read[0]  = 1'b1;
        req_write[0] = 1'b1;
        grant_log.delete();
        serve($urandom, 1, 1, 1'b0, served);
        serve($urandom, 0, 2, 1'b0, served);
        check("dual_op_grants", 32'(grant_log.size()), 32'd2);

        // Reset while in WAIT aborts silently and restores priority
        spi_read_data = $urandom;
        req_read[1] = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("reset_wait");
        reset       = 1'b0;
        req_read[1] = 1'b0;
        model_last  = NUM_REQ - 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_reset_no_ack", 32'(req_ack), 32'd0);
        end
        grant_log.delete();
        wd[0]     = $urandom;
        wd[1]     = $urandom;
        req_write = '1;
        serve($urandom, 0, 1, 1'b0, served);
        serve($urandom, 0, 1, 1'b0, served);
        if (grant_log.size() == 2) begin
            check("post_reset_first", 32'(grant_log[0]), 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 8; n++) begin
            id = $urandom_range(0, NUM_REQ - 1);
            if ($urandom_range(0, 1) == 1) begin
                wd[id]        = $urandom;
                req_write[id] = 1'b1;
            end else begin
                req_read[id] = 1'b1;
            end
            serve($urandom, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0, served);
        end

`ifdef SPI_ARB_TIMEOUT_EN
        // No response: ack and err together after TIMEOUT WAIT cycles
        req_read[0] = 1'b1;
        step();
        check("to_strobe", 32'(spi_read), 32'd1);
        step();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
            check("to_no_early_ack", 32'(req_ack), 32'd0);
        end
        step();
        check("to_ack", 32'(req_ack), 32'd1);
        check("to_err", 32'(req_err), 32'd1);
        check("to_rdata_zero", req_read_data, 32'd0);
        req_read[0] = 1'b0;
        step();
        check("to_idle", 32'(busy), 32'd0);

        // Response in the last WAIT cycle wins over the timeout
        req_read[0] = 1'b1;
        step();
        step();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
            check("to2_no_early_ack", 32'(req_ack), 32'd0);
        end
        spi_read_data     = 32'hA5A55A5A;
        spi_read_response = 1'b1;
        step();
        check("to2_ack", 32'(req_ack), 32'd1);
        check("to2_no_err", 32'(req_err), 32'd0);
        check("to2_rdata", req_read_data, 32'hA5A55A5A);
        spi_read_response = 1'b0;
        req_read[0]       = 1'b0;
        step();
        check("to2_idle", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
